// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for the pipelined immediate extender.
// Both sides use valid/ready: a beat moves on a clock edge where valid and
// ready are both high; the sender holds its payload steady until that edge,
// and ready never depends combinationally on the other side's valid or ready.
interface imm_extend_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [2:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;
  logic [1:0]       occupancy;

  // Producer of immediates and consumer of results (decode side / bench).
  modport master (
    output in_valid, in_data, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_err, occupancy
  );

  // The extender itself.
  modport slave (
    input  in_valid, in_data, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_err, occupancy
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: widens an IN_W-bit immediate to OUT_W bits
// in one of five modes and queues the result, tag and error flag in a
// registered 2-entry skid buffer so decode can stall without losing beats.
// The fill level (occupancy) doubles as the observable buffer state.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input logic               clk,
  input logic               rst_n,
  imm_extend_pipe_if.slave  bus
);

  localparam logic [2:0] MODE_ZERO   = 3'd0;
  localparam logic [2:0] MODE_SIGN   = 3'd1;
  localparam logic [2:0] MODE_UPPER  = 3'd2;
  localparam logic [2:0] MODE_BYTE_S = 3'd3;
  localparam logic [2:0] MODE_BYTE_Z = 3'd4;

  logic [OUT_W-1:0] ent_data [2];
  logic [TAG_W-1:0] ent_tag  [2];
  logic             ent_err  [2];
  logic             head;
  logic             tail;
  logic [1:0]       count;
  logic [1:0]       count_next;
  logic             ready_q;

  logic             push;
  logic             pop;
  logic [OUT_W-1:0] ext_data;
  logic             ext_err;
  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] bzext;
  logic [OUT_W-1:0] bsext;

  // Extension of the incoming immediate; captured into the tail at push.
  always_comb begin
    zext = OUT_W'(bus.in_data);
    sext = zext;
    for (int i = IN_W; i < OUT_W; i++) sext[i] = bus.in_data[IN_W-1];
    bzext = OUT_W'(bus.in_data[7:0]);
    bsext = bzext;
    for (int i = 8; i < OUT_W; i++) bsext[i] = bus.in_data[7];
    ext_data = '0;
    ext_err  = 1'b0;
    case (bus.in_mode)
      MODE_ZERO:   ext_data = zext;
      MODE_SIGN:   ext_data = sext;
      MODE_UPPER:  ext_data = zext << (OUT_W - IN_W);
      MODE_BYTE_S: ext_data = bsext;
      MODE_BYTE_Z: ext_data = bzext;
      default:     ext_err  = 1'b1;
    endcase
  end

  // Handshake qualifiers and next fill level.
  always_comb begin
    push = bus.in_valid & ready_q;
    pop  = (count != 2'd0) & bus.out_ready;
    case ({push, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // Buffer storage, pointers and a registered ready that only looks at the
  // next fill level, so out_ready never reaches in_ready combinationally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        ent_data[i] <= '0;
        ent_tag[i]  <= '0;
        ent_err[i]  <= 1'b0;
      end
      head    <= 1'b0;
      tail    <= 1'b0;
      count   <= 2'd0;
      ready_q <= 1'b0;
    end else begin
      if (push) begin
        ent_data[tail] <= ext_data;
        ent_tag[tail]  <= bus.in_tag;
        ent_err[tail]  <= ext_err;
        tail           <= ~tail;
      end
      if (pop) head <= ~head;
      count   <= count_next;
      ready_q <= (count_next != 2'd2);
    end
  end

  assign bus.in_ready  = ready_q;
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_data  = ent_data[head];
  assign bus.out_tag   = ent_tag[head];
  assign bus.out_err   = ent_err[head];
  assign bus.occupancy = count;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe with default parameters.
module tb_imm_extend_pipe;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [37:0] exp_q[$];

  imm_extend_pipe_if #(.IN_W(16), .OUT_W(32), .TAG_W(5)) bus ();

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Clock and reset defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference extension for 16 -> 32.
  function automatic logic [31:0] ref_ext(input logic [15:0] d, input logic [2:0] m);
    case (m)
      3'd0:    return {16'h0000, d};
      3'd1:    return {{16{d[15]}}, d};
      3'd2:    return {d, 16'h0000};
      3'd3:    return {{24{d[7]}}, d[7:0]};
      3'd4:    return {24'h000000, d[7:0]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [2:0] m, input logic [4:0] t);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_mode  = m;
    bus.in_tag   = t;
  endtask

  // Push one beat into an empty/streaming buffer and check it one edge later.
  task automatic beat(input string tag, input logic [15:0] d, input logic [2:0] m,
                      input logic [4:0] t, input logic [31:0] exp_d, input logic exp_e);
    drive(1'b1, d, m, t);
    tick();
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_data"},  64'(bus.out_data),  64'(exp_d));
    check({tag, "_err"},   64'(bus.out_err),   64'(exp_e));
    check({tag, "_tag"},   64'(bus.out_tag),   64'(t));
  endtask

  logic [15:0] sw_d [5] = '{16'h8001, 16'h8001, 16'h1234, 16'h0080, 16'h12F0};
  logic [2:0]  sw_m [5] = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd4};
  logic [31:0] sw_e [5] = '{32'hFFFF8001, 32'h00008001, 32'h12340000, 32'hFFFFFF80, 32'h000000F0};

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 16'h0, 3'd0, 5'd0);
    repeat (3) tick();
    check("rst_in_ready",  64'(bus.in_ready),  64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_occ",       64'(bus.occupancy), 64'd0);
    check("rst_data",      64'(bus.out_data),  64'd0);
    check("rst_tag",       64'(bus.out_tag),   64'd0);
    check("rst_err",       64'(bus.out_err),   64'd0);
    rst_n = 1'b1;
    tick();
    check("rel_in_ready", 64'(bus.in_ready), 64'd1);

    // Mode sweep, back-to-back with out_ready high.
    for (int i = 0; i < 5; i++) beat($sformatf("sweep%0d", i), sw_d[i], sw_m[i], 5'(i + 1), sw_e[i], 1'b0);
    // Illegal mode then a legal one.
    beat("illegal", 16'hABCD, 3'd6, 5'd7, 32'h0, 1'b1);
    beat("after_ill", 16'h0001, 3'd1, 5'd8, 32'h00000001, 1'b0);
    drive(1'b0, 16'h0, 3'd0, 5'd0);
    tick();
    check("drain_valid", 64'(bus.out_valid), 64'd0);
    check("drain_occ",   64'(bus.occupancy), 64'd0);

    // Backpressure: tags 1,2 fill the buffer, tag 3 is held off.
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h0011, 3'd0, 5'd1);
    tick();
    check("bp1_occ", 64'(bus.occupancy), 64'd1);
    check("bp1_tag", 64'(bus.out_tag),   64'd1);
    drive(1'b1, 16'h0022, 3'd0, 5'd2);
    tick();
    check("bp2_occ",   64'(bus.occupancy), 64'd2);
    check("bp2_ready", 64'(bus.in_ready),  64'd0);
    drive(1'b1, 16'h0033, 3'd0, 5'd3);
    tick();
    check("bp3_occ",   64'(bus.occupancy), 64'd2);
    check("bp3_ready", 64'(bus.in_ready),  64'd0);
    check("bp3_tag",   64'(bus.out_tag),   64'd1);
    check("bp3_data",  64'(bus.out_data),  64'h11);
    // Full with traffic on both sides: pop only.
    bus.out_ready = 1'b1;
    tick();
    check("full_pop_occ",   64'(bus.occupancy), 64'd1);
    check("full_pop_tag",   64'(bus.out_tag),   64'd2);
    check("full_pop_ready", 64'(bus.in_ready),  64'd1);
    // Now push and pop together at occupancy 1.
    tick();
    check("pp_occ",  64'(bus.occupancy), 64'd1);
    check("pp_tag",  64'(bus.out_tag),   64'd3);
    check("pp_data", 64'(bus.out_data),  64'h33);
    drive(1'b0, 16'h0, 3'd0, 5'd0);
    tick();
    check("bp_drain_valid", 64'(bus.out_valid), 64'd0);

    // Streaming random beats against the reference model.
    for (int i = 0; i < 32; i++) begin
      logic [15:0] d;
      logic [2:0]  m;
      logic [4:0]  t;
      logic [37:0] exp;
      d = 16'($urandom_range(0, 65535));
      m = 3'($urandom_range(0, 7));
      t = 5'($urandom_range(0, 31));
      exp_q.push_back({(m > 3'd4), t, ref_ext(d, m)});
      drive(1'b1, d, m, t);
      tick();
      check("st_valid", 64'(bus.out_valid), 64'd1);
      check("st_occ_le1", 64'(bus.occupancy <= 2'd1), 64'd1);
      exp = exp_q.pop_front();
      check("st_beat", 64'({bus.out_err, bus.out_tag, bus.out_data}), 64'(exp));
    end
    drive(1'b0, 16'h0, 3'd0, 5'd0);
    tick();
    check("st_drain", 64'(bus.out_valid), 64'd0);

    // Reset mid-operation with a full buffer.
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h00AA, 3'd0, 5'd10);
    tick();
    drive(1'b1, 16'h00BB, 3'd0, 5'd11);
    tick();
    check("mr_occ_full", 64'(bus.occupancy), 64'd2);
    drive(1'b0, 16'h0, 3'd0, 5'd0);
    rst_n = 1'b0;
    tick();
    check("mr_valid", 64'(bus.out_valid), 64'd0);
    check("mr_occ",   64'(bus.occupancy), 64'd0);
    check("mr_ready", 64'(bus.in_ready),  64'd0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    check("mr_rel_ready", 64'(bus.in_ready),  64'd1);
    check("mr_rel_valid", 64'(bus.out_valid), 64'd0);
    tick();
    check("mr_no_ghost", 64'(bus.out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, pipelined immediate extender for the CPU datapath. Successor to the plain combinational 16-to-32 sign extender.
- Widens an IN_W-bit immediate to OUT_W bits using one of five run-time modes: zero, sign, upper-shift, byte-sign and byte-zero.
- Results pass through a registered 2-entry skid buffer with valid/ready handshakes on both sides, plus an opaque tag, so decode can stall without losing immediates.

Parameters:
IN_W, 16, immediate input width; legal range 8 <= IN_W <= OUT_W.
OUT_W, 32, extended output width.
TAG_W, 5, sideband tag width (e.g. destination register); carried unchanged.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous active-low reset.
in_valid  input  1  input beat offered.
in_ready  output  1  block can accept a beat this cycle.
in_data  input  IN_W  raw immediate.
in_mode  input  3  extension mode.
in_tag  input  TAG_W  sideband, passed through unchanged.
out_valid  output  1  out_data/out_tag/out_err hold a valid beat.
out_ready  input  1  consumer accepts the beat.
out_data  output  OUT_W  extended immediate.
out_tag  output  TAG_W  tag of the current output beat.
out_err  output  1  current beat used an illegal mode.
occupancy  output  2  entries held (0..2).

Behaviour:
- Clock and reset: one clock domain. Synchronous active-low reset, sampled on the rising edge of clk.
- Reset values: out_valid=0, out_data=0, out_tag=0, out_err=0, occupancy=0, both buffer entries cleared. in_ready=0 while rst_n=0; in_ready=1 on the first cycle after release.
- Extension (combinational on the input side, captured at push):
  - mode 0 ZERO: {0, in_data}.
  - mode 1 SIGN: replicate in_data[IN_W-1] into the upper OUT_W-IN_W bits.
  - mode 2 UPPER: in_data placed in bits [OUT_W-1 : OUT_W-IN_W], lower bits 0. When IN_W==OUT_W this equals in_data.
  - mode 3 BYTE_S: sign-extend in_data[7:0] to OUT_W.
  - mode 4 BYTE_Z: zero-extend in_data[7:0] to OUT_W.
  - modes 5-7: result 0, err=1. For every legal mode err=0.
- Push/pop: push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = (occupancy < 2), derived only from registered state. It never depends on out_ready in the same cycle.
- Latency: a beat pushed at edge N appears on out_* after edge N when the buffer was empty (1-cycle latency). Throughput is 1 beat/cycle when out_ready is held high.
- Ordering: strict FIFO. Head entry drives out_*; second entry is the skid.
- Occupancy transitions:
  - push only: +1.
  - pop only: -1.
  - push & pop in the same cycle: unchanged, head advances, new beat enters the tail.
  - neither: hold.
- Full (occupancy=2): in_ready=0, so in_valid is ignored. A pop in that cycle frees a slot; in_ready rises the next cycle.
- Empty (occupancy=0): out_valid=0. out_data/out_tag/out_err hold their last values but are don't-care.
- Output stability: while out_valid=1 and out_ready=0, out_data/out_tag/out_err stay stable.
- Input-side protocol: in_* may change freely while in_ready=0.
- Reset mid-operation: all buffered beats are discarded, with no partial output. Values return to the reset state at the next edge with rst_n=0.
- Pointer wrap: the internal head/tail index is 1 bit and toggles on each pop/push respectively.
- Design constraint: no combinational path from out_ready to in_ready.

Test Plan:
- Mode sweep, default params, out_ready=1:
  - 0x8001/mode1 -> 0xFFFF8001; 0x8001/mode0 -> 0x00008001.
  - 0x1234/mode2 -> 0x12340000.
  - 0x0080/mode3 -> 0xFFFFFF80; 0x12F0/mode4 -> 0x000000F0.
  - Each beat appears 1 cycle after push, err=0.
- Illegal mode: 0xABCD/mode6, tag 7 -> out_data=0, out_err=1, out_tag=7. A following 0x0001/mode1 -> 0x00000001, err=0.
- Backpressure: out_ready=0, offer tags 1,2,3 back-to-back -> tags 1,2 accepted, occupancy=2, in_ready=0, tag 3 held off. Raise out_ready -> outputs 1,2,3 in order, no duplicates.
- Full with simultaneous traffic: occupancy=2, out_ready=1, in_valid=1 -> one pop and no push that cycle. in_ready=1 the next cycle; push and pop then proceed together at occupancy 1.
- Streaming: 32 random beats with out_ready=1 continuously -> one output per cycle, occupancy never exceeds 1, all results match the reference model.
- Reset mid-operation: occupancy=2, drive rst_n=0 for one cycle -> out_valid=0, occupancy=0, in_ready=0 during reset and 1 after. Buffered beats never appear.
